axi_ram_responder: RTL and testbench
====================================

# axi_ram_responder

AXI3 slave memory model that answers the bus traffic produced by the CPU's CBus-to-AXI converter, replacing the external RAM during simulation and FPGA smoke tests. Holds a flop-based word array and serves one read burst and one write burst concurrently, each through its own small state machine. Supports INCR, FIXED and WRAP bursts of 4-byte beats, byte strobes and SLVERR reporting.

## Interface
- MEM_WORDS_LOG, 10, log2 of memory size in 32-bit words (4 KiB default)
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high
- arid  in  4  read ID; arlen in 4; arsize in 3; arburst in 2; araddr in 32
- arvalid  in  1 / arready  out  1  read address handshake
- rid  out  4; rdata  out  32; rresp  out  2; rlast  out  1
- rvalid  out  1 / rready  in  1  read data handshake
- awid in 4; awaddr in 32; awlen in 4; awsize in 3; awburst in 2
- awvalid  in  1 / awready  out  1  write address handshake
- wid in 4; wdata in 32; wstrb in 4; wlast in 1
- wvalid  in  1 / wready  out  1  write data handshake
- bid  out  4; bresp  out  2; bvalid  out  1 / bready  in  1  write response
- arlock/arcache/arprot and aw equivalents: not ports; ignored upstream.

## Operation
- Read FSM: R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: arready=1; on arvalid&arready latch id, addr, len, burst, error flag; go R_DATA; beat count=0.
  - R_DATA: rvalid=1, rid=latched id, rdata=mem[addr[MEM_WORDS_LOG+1:2]] (combinational read of array), rlast=(count==len). On rvalid&rready: advance addr, count+1; if rlast go R_IDLE.
- Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: awready=1; on handshake latch id, addr, len, burst, error flag; go W_DATA.
  - W_DATA: wready=1; each w handshake writes byte lanes with wstrb[i]=1 unless error flag; advance addr; after len+1 beats go W_RESP. wlast not equal to (count==len) sets error flag; beat count alone ends the burst.
  - W_RESP: bvalid=1, bid=latched id, bresp=OKAY(00)/SLVERR(10); on bready go W_IDLE.
- Address advance: FIXED(00) unchanged; INCR(01) addr+4; WRAP(10) mask=(len+1)*4-1, next=(addr&~mask)|((addr+4)&mask).
- Error flag (SLVERR, no memory effect, rdata=0): size!=2; burst==11; WRAP with len not in {1,3,7,15}; any beat address >= 4<<MEM_WORDS_LOG; addr[1:0]!=0. Read error reported per beat on rresp; write error reported once on bresp.
- wid ignored (no interleaving); rid/bid echo latched ID.
- Read and write FSMs independent; both may be active simultaneously.

## Timing
- Reset: state R_IDLE/W_IDLE; arready=1, awready=1, rvalid=0, wready=0, bvalid=0, rlast=0, rresp=0, bresp=0, rid=0, bid=0, rdata=0. Memory contents not reset.
- rdata forced to 0 whenever rvalid=0.
- Read latency: ar handshake at edge N -> first rvalid in cycle after N; one beat per cycle with rready held high; len+1 beats total.
- Write: first wready cycle after aw handshake; bvalid cycle after last w beat; awready low until b handshake completes.
- Outputs held stable while valid=1 and ready=0.
- Same-cycle write beat and read beat to same word: read returns old data; write visible next cycle.
- Reset mid-burst: burst abandoned immediately, no response issued, partial writes already performed remain.

## Test plan
- Single write: aw addr 0x40 len 0 INCR, wdata 0xDEADBEEF wstrb 1111 -> bresp 00, bid echoes; then read 0x40 len 0 -> rdata 0xDEADBEEF, rlast=1, rresp 00.
- INCR read burst len 3 from 0x100 after writing 1,2,3,4 there, rready toggled 1/0 -> four beats 1,2,3,4, data stable during stalls, rlast only on 4th.
- WRAP read len 3 at 0x108 -> addresses 0x108,0x10C,0x100,0x104; byte-strobe write wstrb 0101 of 0xAABBCCDD over 0x11223344 -> 0x11BB33DD.
- Errors: arsize=1 -> 1 beat rresp 10 rdata 0; write to 0x1000 (out of range) -> bresp 10, memory unchanged; wlast early -> bresp 10.
- Concurrent read burst and write burst with different IDs -> both complete, rid/bid correct, no cross-corruption.
- Assert reset during R_DATA beat 2 of 4 -> rvalid=0, arready=1 next cycle; new read succeeds.

Source files
------------

// File: rtl/axi_ram_responder.sv
// AXI3 slave memory model: flop-based word array serving one read burst and one
// write burst concurrently, with INCR/FIXED/WRAP addressing, byte strobes and SLVERR.
module axi_ram_responder #(
  parameter int MEM_WORDS_LOG = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  arid,
  input  logic [3:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int          WORDS       = 1 << MEM_WORDS_LOG;
  localparam logic [31:0] MEM_BYTES   = 32'(4) << MEM_WORDS_LOG;
  localparam logic [1:0]  BURST_INCR  = 2'b01;
  localparam logic [1:0]  BURST_WRAP  = 2'b10;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic       {R_IDLE, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  logic [31:0] mem [WORDS];

  // Interleaving is never produced upstream, so the write ID is not needed.
  logic unused_wid;
  assign unused_wid = ^wid;

  function automatic logic in_range(input logic [31:0] addr);
    return addr < MEM_BYTES;
  endfunction

  // WRAP mask (len+1)*4-1 equals {len, 2'b11}.
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [3:0] len,
                                            input logic [1:0] burst);
    logic [31:0] mask;
    mask = {26'd0, len, 2'b11};
    case (burst)
      BURST_INCR: next_addr = addr + 32'd4;
      BURST_WRAP: next_addr = (addr & ~mask) | ((addr + 32'd4) & mask);
      default:    next_addr = addr;
    endcase
  endfunction

  function automatic logic req_error(input logic [2:0] size, input logic [1:0] burst,
                                     input logic [3:0] len, input logic [31:0] addr);
    return (size != 3'd2) || (burst == 2'b11) ||
           ((burst == BURST_WRAP) && !(len inside {4'd1, 4'd3, 4'd7, 4'd15})) ||
           (addr[1:0] != 2'b00) || !in_range(addr);
  endfunction

  // ---------------- read channel ----------------
  r_state_e    r_state, r_state_next;
  logic [3:0]  r_id, r_len, r_cnt;
  logic [31:0] r_addr;
  logic [1:0]  r_burst;
  logic        r_err, r_beat_err;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    r_state_next = r_state;
    arready      = 1'b0;
    rvalid       = 1'b0;
    rlast        = 1'b0;
    rresp        = RESP_OKAY;
    rdata        = '0;
    r_beat_err   = r_err || !in_range(r_addr);
    case (r_state)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) r_state_next = R_DATA;
      end
      R_DATA: begin
        rvalid = 1'b1;
        rlast  = (r_cnt == r_len);
        rresp  = r_beat_err ? RESP_SLVERR : RESP_OKAY;
        rdata  = r_beat_err ? '0 : mem[r_addr[MEM_WORDS_LOG+1:2]];
        if (rready && rlast) r_state_next = R_IDLE;
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  assign rid = r_id;

  // NOTE: state and datapath registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= R_IDLE;
      r_id    <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_burst <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= r_state_next;
      if (arvalid && arready) begin
        r_id    <= arid;
        r_len   <= arlen;
        r_cnt   <= '0;
        r_addr  <= araddr;
        r_burst <= arburst;
        r_err   <= req_error(arsize, arburst, arlen, araddr);
      end else if (rvalid && rready) begin
        r_addr <= next_addr(r_addr, r_len, r_burst);
        r_cnt  <= r_cnt + 4'd1;
      end
    end
  end

  // ---------------- write channel ----------------
  w_state_e    w_state, w_state_next;
  logic [3:0]  w_id, w_len, w_cnt;
  logic [31:0] w_addr;
  logic [1:0]  w_burst;
  logic        w_err, w_beat_err, mem_we;

  always_comb begin
    w_state_next = w_state;
    awready      = 1'b0;
    wready       = 1'b0;
    bvalid       = 1'b0;
    bresp        = RESP_OKAY;
    w_beat_err   = w_err || !in_range(w_addr) || (wlast != (w_cnt == w_len));
    case (w_state)
      W_IDLE: begin
        awready = 1'b1;
        if (awvalid) w_state_next = W_DATA;
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid && (w_cnt == w_len)) w_state_next = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        bresp  = w_err ? RESP_SLVERR : RESP_OKAY;
        if (bready) w_state_next = W_IDLE;
      end
      default: w_state_next = W_IDLE;
    endcase
    mem_we = wvalid && wready && !w_beat_err;
  end

  assign bid = w_id;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state <= W_IDLE;
      w_id    <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_addr  <= '0;
      w_burst <= '0;
      w_err   <= 1'b0;
    end else begin
      w_state <= w_state_next;
      if (awvalid && awready) begin
        w_id    <= awid;
        w_len   <= awlen;
        w_cnt   <= '0;
        w_addr  <= awaddr;
        w_burst <= awburst;
        w_err   <= req_error(awsize, awburst, awlen, awaddr);
      end else if (wvalid && wready) begin
        w_addr <= next_addr(w_addr, w_len, w_burst);
        w_cnt  <= w_cnt + 4'd1;
        w_err  <= w_beat_err;
      end
    end
  end

  // NOTE: the array has no reset; contents survive reset like a real RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[w_addr[MEM_WORDS_LOG+1:2]][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_ram_responder.sv
// Directed bench for axi_ram_responder: single/burst/strobe writes, INCR/WRAP/FIXED
// reads with stalls, error responses, concurrent traffic and reset mid-burst.
module tb_axi_ram_responder;

  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  arid, arlen, awid, awlen, wid, wstrb;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst;
  logic [31:0] araddr, awaddr, wdata;
  logic        arvalid, rready, awvalid, wlast, wvalid, bready;
  logic        arready, rlast, rvalid, awready, wready, bvalid;
  logic [3:0]  rid, bid;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;

  logic [31:0] wr_data [16];
  logic [3:0]  wr_strb [16];
  logic [31:0] exp_data [16];
  int n_checks = 0;
  int n_pass   = 0;

  axi_ram_responder #(.MEM_WORDS_LOG(10)) dut (
    .clk(clk), .reset(reset),
    .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst), .araddr(araddr),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // All tasks start and end 1 ns after a rising edge.
  task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [1:0] burst, input int last_beat,
                             input logic [1:0] exp_resp, input string tag);
    int n;
    awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = burst; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(posedge clk); #1; n++; end
    check({tag, "_awready"}, awready, 1'b1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1'b1; wdata = wr_data[i]; wstrb = wr_strb[i]; wlast = (i == last_beat);
      n = 0;
      while (!wready && n < 50) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    check({tag, "_bvalid_latency"}, bvalid, 1'b1);
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < 50) begin @(posedge clk); #1; n++; end
    check({tag, "_bresp"}, bresp, exp_resp);
    check({tag, "_bid"}, bid, id);
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [1:0] burst, input logic [2:0] size, input bit stall,
                            input logic [1:0] exp_resp, input string tag);
    int n, beat, cyc;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(posedge clk); #1; n++; end
    check({tag, "_arready"}, arready, 1'b1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    check({tag, "_first_rvalid"}, rvalid, 1'b1);
    beat = 0; cyc = 0;
    while (beat <= int'(len) && cyc < 100) begin
      rready = stall ? cyc[0] : 1'b1;
      if (rvalid) begin
        check($sformatf("%s_data%0d", tag, beat), rdata, exp_data[beat]);
        check($sformatf("%s_last%0d", tag, beat), rlast, beat == int'(len));
        check($sformatf("%s_resp%0d", tag, beat), rresp, exp_resp);
        check($sformatf("%s_rid%0d", tag, beat), rid, id);
        if (rready) beat++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    rready = 1'b0;
    check({tag, "_beats"}, beat, int'(len) + 1);
    check({tag, "_idle_after"}, rvalid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    {arid, arlen, awid, awlen, wid, wstrb} = '0;
    {arsize, awsize, arburst, awburst} = '0;
    {araddr, awaddr, wdata} = '0;
    {arvalid, rready, awvalid, wlast, wvalid, bready} = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_arready", arready, 1'b1);
    check("rst_awready", awready, 1'b1);
    check("rst_rvalid",  rvalid,  1'b0);
    check("rst_wready",  wready,  1'b0);
    check("rst_bvalid",  bvalid,  1'b0);
    check("rst_rlast",   rlast,   1'b0);
    check("rst_rresp",   rresp,   2'b00);
    check("rst_bresp",   bresp,   2'b00);
    check("rst_rid",     rid,     4'd0);
    check("rst_bid",     bid,     4'd0);
    check("rst_rdata",   rdata,   32'd0);
    reset = 1'b0;

    // Single write then read back.
    wr_data[0] = 32'hDEADBEEF; wr_strb[0] = 4'hF;
    write_burst(4'd3, 32'h40, 4'd0, INCR, 0, 2'b00, "wr_single");
    exp_data[0] = 32'hDEADBEEF;
    read_burst(4'd5, 32'h40, 4'd0, INCR, 3'd2, 1'b0, 2'b00, "rd_single");

    // INCR burst write 1..4 and stalled read.
    for (int i = 0; i < 4; i++) begin wr_data[i] = 32'(i + 1); wr_strb[i] = 4'hF; end
    write_burst(4'd1, 32'h100, 4'd3, INCR, 3, 2'b00, "wr_incr");
    for (int i = 0; i < 4; i++) exp_data[i] = 32'(i + 1);
    read_burst(4'd2, 32'h100, 4'd3, INCR, 3'd2, 1'b1, 2'b00, "rd_incr_stall");

    // WRAP from 0x108: 0x108, 0x10C, 0x100, 0x104.
    exp_data[0] = 32'd3; exp_data[1] = 32'd4; exp_data[2] = 32'd1; exp_data[3] = 32'd2;
    read_burst(4'd4, 32'h108, 4'd3, WRAP, 3'd2, 1'b0, 2'b00, "rd_wrap");

    // FIXED stays on 0x104.
    exp_data[0] = 32'd2; exp_data[1] = 32'd2;
    read_burst(4'd6, 32'h104, 4'd1, FIXED, 3'd2, 1'b0, 2'b00, "rd_fixed");

    // Byte strobes: 0xAABBCCDD with 0101 over 0x11223344.
    wr_data[0] = 32'h11223344; wr_strb[0] = 4'hF;
    write_burst(4'd2, 32'h200, 4'd0, INCR, 0, 2'b00, "wr_full");
    wr_data[0] = 32'hAABBCCDD; wr_strb[0] = 4'b0101;
    write_burst(4'd2, 32'h200, 4'd0, INCR, 0, 2'b00, "wr_strb");
    exp_data[0] = 32'h11BB33DD;
    read_burst(4'd7, 32'h200, 4'd0, INCR, 3'd2, 1'b0, 2'b00, "rd_strb");

    // Read errors: bad size, WRAP with illegal length.
    exp_data[0] = 32'd0; exp_data[1] = 32'd0; exp_data[2] = 32'd0;
    read_burst(4'd8, 32'h40, 4'd0, INCR, 3'd1, 1'b0, 2'b10, "rd_badsize");
    read_burst(4'd9, 32'h100, 4'd2, WRAP, 3'd2, 1'b0, 2'b10, "rd_badwrap");

    // Out-of-range write aliases word 0 by index; word 0 must stay untouched.
    wr_data[0] = 32'h0BADF00D; wr_strb[0] = 4'hF;
    write_burst(4'd1, 32'h0, 4'd0, INCR, 0, 2'b00, "wr_word0");
    wr_data[0] = 32'hFFFFFFFF;
    write_burst(4'd12, 32'h1000, 4'd0, INCR, 0, 2'b10, "wr_oor");
    exp_data[0] = 32'h0BADF00D;
    read_burst(4'd1, 32'h0, 4'd0, INCR, 3'd2, 1'b0, 2'b00, "rd_word0");

    // wlast on the first of two beats.
    wr_data[0] = 32'h55; wr_data[1] = 32'h66; wr_strb[0] = 4'hF; wr_strb[1] = 4'hF;
    write_burst(4'd13, 32'h300, 4'd1, INCR, 0, 2'b10, "wr_early_last");

    // Concurrent write burst and read burst.
    for (int i = 0; i < 4; i++) begin wr_data[i] = 32'hA0 + 32'(i); wr_strb[i] = 4'hF; end
    for (int i = 0; i < 4; i++) exp_data[i] = 32'(i + 1);
    fork
      write_burst(4'd7, 32'h400, 4'd3, INCR, 3, 2'b00, "cc_wr");
      read_burst(4'd9, 32'h100, 4'd3, INCR, 3'd2, 1'b0, 2'b00, "cc_rd");
    join
    for (int i = 0; i < 4; i++) exp_data[i] = 32'hA0 + 32'(i);
    read_burst(4'd10, 32'h400, 4'd3, INCR, 3'd2, 1'b0, 2'b00, "cc_rdback");

    // Reset during beat 2 of a 4-beat read.
    arid = 4'd11; araddr = 32'h100; arlen = 4'd3; arsize = 3'd2; arburst = INCR; arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0; rready = 1'b1;
    check("rst_mid_beat0", rdata, 32'd1);
    @(posedge clk); #1;
    check("rst_mid_beat1", rdata, 32'd2);
    @(posedge clk); #1;
    check("rst_mid_beat2_valid", rvalid, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_rvalid", rvalid, 1'b0);
    check("rst_mid_arready", arready, 1'b1);
    check("rst_mid_rdata", rdata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; rready = 1'b0;
    check("rst_mid_rvalid_after", rvalid, 1'b0);
    exp_data[0] = 32'hDEADBEEF;
    read_burst(4'd14, 32'h40, 4'd0, INCR, 3'd2, 1'b0, 2'b00, "rd_after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
